fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_pkg.sv | 24 ++
 rtl/fetch_skid_buf.sv | 56 +++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch slice: word size, FSM encodings,
// reset/bubble values and the wrapping PC increment.
package fetch_unit_pkg;

  localparam int WORD_SIZE = 16;

  typedef logic [WORD_SIZE-1:0] word_t;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_HOLD   = 2'd1,
    ST_HALTED = 2'd2
  } fetch_state_e;

  localparam word_t PC_RESET  = 16'h0000;
  localparam word_t IR_BUBBLE = 16'h0000;
  localparam word_t WORD_ONE  = 16'h0001;

  // Natural modulo-2^16 wrap: 0xFFFF + 1 -> 0x0000.
  function automatic word_t word_inc(input word_t w);
    return w + WORD_ONE;
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry skid register holding an instruction word and its link PC while
// decode is stalled.
module fetch_skid_buf
  import fetch_unit_pkg::*;
(
  input  logic  clk,
  input  logic  reset_n,
  input  logic  load,
  input  logic  clear,
  input  word_t load_data,
  input  word_t load_pc_next,
  output word_t data,
  output word_t pc_next,
  output logic  valid
);

  word_t data_q, data_d;
  word_t pc_next_q, pc_next_d;
  logic  valid_q, valid_d;

  // Next-entry selection: clear wins over load, otherwise hold.
  always_comb begin
    data_d    = data_q;
    pc_next_d = pc_next_q;
    valid_d   = valid_q;
    if (clear) begin
      data_d    = IR_BUBBLE;
      pc_next_d = PC_RESET;
      valid_d   = 1'b0;
    end else if (load) begin
      data_d    = load_data;
      pc_next_d = load_pc_next;
      valid_d   = 1'b1;
    end else begin
      valid_d   = valid_q;
    end
  end

  // Entry storage with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      data_q    <= IR_BUBBLE;
      pc_next_q <= PC_RESET;
      valid_q   <= 1'b0;
    end else begin
      data_q    <= data_d;
      pc_next_q <= pc_next_d;
      valid_q   <= valid_d;
    end
  end

  assign data    = data_q;
  assign pc_next = pc_next_q;
  assign valid   = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues PC-addressed reads, presents one instruction
// per cycle to decode, and absorbs a single response across a decode stall.
module fetch_unit
  import fetch_unit_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  output logic                 i_readM,
  output logic [WORD_SIZE-1:0] i_address,
  input  logic [WORD_SIZE-1:0] i_data,
  input  logic                 i_ready,
  input  logic                 stall,
  input  logic                 redirect,
  input  logic [WORD_SIZE-1:0] redirect_pc,
  input  logic                 halt,
  output logic [WORD_SIZE-1:0] ir,
  output logic [WORD_SIZE-1:0] ir_pc_next,
  output logic                 ir_valid,
  output logic [WORD_SIZE-1:0] num_fetch
);

  fetch_state_e state_q, state_d;
  word_t        pc_q, pc_d;
  word_t        ir_q, ir_d;
  word_t        ir_pc_next_q, ir_pc_next_d;
  logic         ir_valid_q, ir_valid_d;
  word_t        num_fetch_q, num_fetch_d;
  logic         i_readm_q, i_readm_d;

  logic         skid_load, skid_clear, skid_valid;
  word_t        skid_data, skid_pc_next;

  fetch_skid_buf u_skid (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (skid_load),
    .clear        (skid_clear),
    .load_data    (i_data),
    .load_pc_next (word_inc(pc_q)),
    .data         (skid_data),
    .pc_next      (skid_pc_next),
    .valid        (skid_valid)
  );

  // Next-state and datapath: halt > halted-lock > redirect > normal fetch/hold.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    ir_pc_next_d = ir_pc_next_q;
    ir_valid_d   = ir_valid_q;
    num_fetch_d  = num_fetch_q;
    skid_load    = 1'b0;
    skid_clear   = 1'b0;
    if (halt) begin
      state_d    = ST_HALTED;
      ir_d       = IR_BUBBLE;
      ir_valid_d = 1'b0;
      skid_clear = 1'b1;
    end else if (state_q == ST_HALTED) begin
      state_d    = ST_HALTED;
    end else if (redirect) begin
      // Any coincident response belongs to the squashed path and is dropped.
      state_d    = ST_FETCH;
      pc_d       = redirect_pc;
      ir_d       = IR_BUBBLE;
      ir_valid_d = 1'b0;
      skid_clear = 1'b1;
    end else begin
      case (state_q)
        ST_FETCH: begin
          if (i_ready && !stall) begin
            ir_d         = i_data;
            ir_pc_next_d = word_inc(pc_q);
            ir_valid_d   = 1'b1;
            pc_d         = word_inc(pc_q);
            num_fetch_d  = word_inc(num_fetch_q);
          end else if (i_ready) begin
            skid_load = 1'b1;
            pc_d      = word_inc(pc_q);
            state_d   = ST_HOLD;
          end else if (!stall) begin
            ir_d       = IR_BUBBLE;
            ir_valid_d = 1'b0;
          end else begin
            state_d = ST_FETCH;
          end
        end
        ST_HOLD: begin
          if (!stall && skid_valid) begin
            ir_d         = skid_data;
            ir_pc_next_d = skid_pc_next;
            ir_valid_d   = 1'b1;
            num_fetch_d  = word_inc(num_fetch_q);
            skid_clear   = 1'b1;
            state_d      = ST_FETCH;
          end else if (!stall) begin
            ir_d       = IR_BUBBLE;
            ir_valid_d = 1'b0;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_HOLD;
          end
        end
        default: begin
          state_d = ST_FETCH;
        end
      endcase
    end
  end

  // Request strobe registered from the next state so it tracks state alone.
  always_comb begin
    i_readm_d = (state_d == ST_FETCH);
  end

  // Architectural state with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_FETCH;
      pc_q         <= PC_RESET;
      ir_q         <= IR_BUBBLE;
      ir_pc_next_q <= PC_RESET;
      ir_valid_q   <= 1'b0;
      num_fetch_q  <= 16'h0000;
      i_readm_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      ir_pc_next_q <= ir_pc_next_d;
      ir_valid_q   <= ir_valid_d;
      num_fetch_q  <= num_fetch_d;
      i_readm_q    <= i_readm_d;
    end
  end

  assign i_readM    = i_readm_q;
  assign i_address  = pc_q;
  assign ir         = ir_q;
  assign ir_pc_next = ir_pc_next_q;
  assign ir_valid   = ir_valid_q;
  assign num_fetch  = num_fetch_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scenario bench for fetch_unit: memory returns 0x1000+address, expected
// instructions are queued when the response is driven and popped on delivery.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n, i_ready, stall, redirect, halt;
  logic [15:0] i_data, redirect_pc;
  logic        i_readM, ir_valid;
  logic [15:0] i_address, ir, ir_pc_next, num_fetch;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] pcn;
  } exp_t;

  exp_t        sb[$];
  exp_t        e;
  logic [15:0] model_pc;
  logic [15:0] model_cnt;

  fetch_unit dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .i_readM     (i_readM),
    .i_address   (i_address),
    .i_data      (i_data),
    .i_ready     (i_ready),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .ir          (ir),
    .ir_pc_next  (ir_pc_next),
    .ir_valid    (ir_valid),
    .num_fetch   (num_fetch)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic rdy, input logic stl, input logic rd,
                       input logic hlt, input logic [15:0] rpc);
    i_ready     = rdy;
    stall       = stl;
    redirect    = rd;
    halt        = hlt;
    redirect_pc = rpc;
    i_data      = rdy ? (16'h1000 + model_pc) : 16'h0000;
  endtask

  task automatic push_expected();
    e.ir  = 16'h1000 + model_pc;
    e.pcn = model_pc + 16'h0001;
    sb.push_back(e);
    model_pc  = model_pc + 16'h0001;
    model_cnt = model_cnt + 16'h0001;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 16'h1234);
    tick();
    tick();
    checks++;
    if (ir !== 16'h0000 || ir_pc_next !== 16'h0000 || ir_valid !== 1'b0 ||
        num_fetch !== 16'h0000 || i_address !== 16'h0000) begin
      errors++;
      $display("FAIL reset_state ir=%h pcn=%h v=%b n=%h a=%h expected all zero",
               ir, ir_pc_next, ir_valid, num_fetch, i_address);
    end
    reset_n = 1'b1;
    model_pc = 16'h0000;
    model_cnt = 16'h0000;
    sb.delete();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    checks++;
    if (i_readM !== 1'b1 || i_address !== 16'h0000) begin
      errors++;
      $display("FAIL reset_release readM=%b addr=%h expected 1 0000", i_readM, i_address);
    end
  endtask

  task automatic test_stream();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (i_address !== model_pc) begin
        errors++;
        $display("FAIL stream_addr got %h expected %h", i_address, model_pc);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      push_expected();
      tick();
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL stream_sb queue empty");
      end else begin
        e = sb.pop_front();
        if (ir !== e.ir || ir_pc_next !== e.pcn || ir_valid !== 1'b1) begin
          errors++;
          $display("FAIL stream ir=%h pcn=%h v=%b expected %h %h 1",
                   ir, ir_pc_next, ir_valid, e.ir, e.pcn);
        end
      end
    end
    drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    checks++;
    if (num_fetch !== 16'd3) begin
      errors++;
      $display("FAIL stream_count got %0d expected 3", num_fetch);
    end
  endtask

  task automatic test_stall();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    push_expected();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (ir !== 16'h1002 || ir_pc_next !== 16'h0003 || ir_valid !== 1'b1 || i_readM !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold cyc%0d ir=%h pcn=%h v=%b readM=%b expected 1002 0003 1 0",
                 k, ir, ir_pc_next, ir_valid, i_readM);
      end
      drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    e = sb.pop_front();
    checks++;
    if (ir !== e.ir || ir_pc_next !== e.pcn || ir_valid !== 1'b1 ||
        num_fetch !== model_cnt || i_readM !== 1'b1) begin
      errors++;
      $display("FAIL stall_release ir=%h pcn=%h v=%b n=%h readM=%b expected %h %h 1 %h 1",
               ir, ir_pc_next, ir_valid, num_fetch, i_readM, e.ir, e.pcn, model_cnt);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_expected();
    tick();
    e = sb.pop_front();
    checks++;
    if (ir !== e.ir || ir_pc_next !== e.pcn || num_fetch !== model_cnt) begin
      errors++;
      $display("FAIL stall_next ir=%h pcn=%h n=%h expected %h %h %h",
               ir, ir_pc_next, num_fetch, e.ir, e.pcn, model_cnt);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0040);
    tick();
    checks++;
    if (ir_valid !== 1'b0 || ir !== 16'h0000 || i_address !== 16'h0040 || num_fetch !== model_cnt) begin
      errors++;
      $display("FAIL redirect v=%b ir=%h addr=%h n=%h expected 0 0000 0040 %h",
               ir_valid, ir, i_address, num_fetch, model_cnt);
    end
    model_pc = 16'h0040;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_expected();
    tick();
    e = sb.pop_front();
    checks++;
    if (ir !== e.ir || ir_pc_next !== e.pcn || ir_valid !== 1'b1) begin
      errors++;
      $display("FAIL redirect_target ir=%h pcn=%h v=%b expected %h %h 1",
               ir, ir_pc_next, ir_valid, e.ir, e.pcn);
    end
  endtask

  task automatic test_latency();
    for (int n = 0; n < 2; n++) begin
      for (int w = 0; w < 2; w++) begin
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
        tick();
        checks++;
        if (i_readM !== 1'b1 || i_address !== model_pc || ir_valid !== 1'b0) begin
          errors++;
          $display("FAIL latency_wait readM=%b addr=%h v=%b expected 1 %h 0",
                   i_readM, i_address, ir_valid, model_pc);
        end
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
      push_expected();
      tick();
      e = sb.pop_front();
      checks++;
      if (ir !== e.ir || ir_pc_next !== e.pcn || ir_valid !== 1'b1) begin
        errors++;
        $display("FAIL latency_data ir=%h pcn=%h v=%b expected %h %h 1",
                 ir, ir_pc_next, ir_valid, e.ir, e.pcn);
      end
    end
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'hFFFF);
    tick();
    model_pc = 16'hFFFF;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_expected();
    tick();
    e = sb.pop_front();
    checks++;
    if (ir !== e.ir || ir_pc_next !== 16'h0000 || i_address !== 16'h0000) begin
      errors++;
      $display("FAIL wrap ir=%h pcn=%h addr=%h expected %h 0000 0000",
               ir, ir_pc_next, i_address, e.ir);
    end
  endtask

  task automatic test_halt();
    drive(1'b0, 1'b0, 1'b1, 1'b0, 16'h0123);
    tick();
    model_pc = 16'h0123;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++;
    if (i_readM !== 1'b0 || ir_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt readM=%b v=%b expected 0 0", i_readM, ir_valid);
    end
    drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0080);
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (i_readM !== 1'b0 || ir_valid !== 1'b0 || i_address !== model_pc || num_fetch !== model_cnt) begin
        errors++;
        $display("FAIL halt_locked readM=%b v=%b addr=%h n=%h expected 0 0 %h %h",
                 i_readM, ir_valid, i_address, num_fetch, model_pc, model_cnt);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    end
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    model_pc = 16'h0000;
    model_cnt = 16'h0000;
    checks++;
    if (i_readM !== 1'b1 || i_address !== 16'h0000 || num_fetch !== 16'h0000) begin
      errors++;
      $display("FAIL halt_reset readM=%b addr=%h n=%h expected 1 0000 0000",
               i_readM, i_address, num_fetch);
    end
  endtask

  task automatic test_reset_mid_hold();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 16'h0000);
    tick();
    reset_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    tick();
    model_pc = 16'h0000;
    model_cnt = 16'h0000;
    sb.delete();
    checks++;
    if (i_readM !== 1'b1 || ir_valid !== 1'b0 || i_address !== 16'h0000) begin
      errors++;
      $display("FAIL hold_reset readM=%b v=%b addr=%h expected 1 0 0000",
               i_readM, ir_valid, i_address);
    end
    drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    push_expected();
    tick();
    e = sb.pop_front();
    checks++;
    if (ir !== e.ir || ir_pc_next !== e.pcn || num_fetch !== 16'h0001) begin
      errors++;
      $display("FAIL hold_reset_refetch ir=%h pcn=%h n=%h expected %h %h 0001",
               ir, ir_pc_next, num_fetch, e.ir, e.pcn);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    model_pc = 16'h0000;
    model_cnt = 16'h0000;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    @(negedge clk);
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_latency();
    test_wrap();
    test_halt();
    test_reset_mid_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
